// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg
// Shared types and constants for the fetch-stage hazard controller.
//   fetch_state_t  : refill FSM state (RUN, REFILL, DRAIN), 2-bit encoding
//   CNT_W_DEFAULT  : default width of the saturating performance counters
package fetch_ctrl_pkg;

  localparam int CNT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    REFILL = 2'd1,
    DRAIN  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, clears the count
//   inc   : add one this cycle (ignored once saturated)
//   count : current count value
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_d;
  logic [W-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_hazard_ctrl.sv
// fetch_hazard_ctrl
// Sequences the PC register and the F/D/E pipeline registers, arbitrating
// between data-memory stalls, E-stage redirects, load-use hazards and
// instruction-cache misses, and runs the refill handshake FSM.
// Ports:
//   clk, rst       : clock (rising edge), synchronous active-high reset
//   icache_hitF    : F-stage fetch hit (0 = miss)
//   refill_ack     : one-cycle pulse, refill line written
//   load_use_hazD  : D instruction depends on a load in E
//   redirectE      : taken branch / JALR in E
//   dmem_stallM    : data memory busy, freezes F..M
//   pc_en          : PC register enable
//   stallD/stallE  : hold F/D, D/E registers
//   flushD/flushE  : clear F/D, D/E registers to a bubble
//   refill_req     : registered level request to the refill engine
//   miss_cycles    : saturating count of cycles spent in REFILL or DRAIN
//   redirect_cnt   : saturating count of accepted redirects
module fetch_hazard_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             icache_hitF,
  input  logic             refill_ack,
  input  logic             load_use_hazD,
  input  logic             redirectE,
  input  logic             dmem_stallM,
  output logic             pc_en,
  output logic             stallD,
  output logic             stallE,
  output logic             flushD,
  output logic             flushE,
  output logic             refill_req,
  output logic [CNT_W-1:0] miss_cycles,
  output logic [CNT_W-1:0] redirect_cnt
);

  fetch_state_t state_d;
  fetch_state_t state_q;
  logic         refill_req_d;
  logic         refill_req_q;
  logic         redirect_taken;
  logic         miss_active;

  // Control outputs are combinational from the registered state so that a
  // hazard takes effect in the same cycle it is presented.
  always_comb begin
    state_d        = state_q;
    pc_en          = 1'b1;
    stallD         = 1'b0;
    stallE         = 1'b0;
    flushD         = 1'b0;
    flushE         = 1'b0;
    redirect_taken = 1'b0;

    if (rst) begin
      state_d = RUN;
      pc_en   = 1'b0;
      flushD  = 1'b1;
      flushE  = 1'b1;
    end else if (dmem_stallM) begin
      // Whole front end frozen; a pending redirect stays in E and is
      // taken once the memory releases.
      pc_en  = 1'b0;
      stallD = 1'b1;
      stallE = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (redirectE) begin
            flushD         = 1'b1;
            flushE         = 1'b1;
            redirect_taken = 1'b1;
          end else if (load_use_hazD) begin
            // Load-use beats a simultaneous miss; the miss is seen again
            // next cycle because the PC does not advance.
            pc_en  = 1'b0;
            stallD = 1'b1;
            flushE = 1'b1;
          end else if (!icache_hitF) begin
            pc_en   = 1'b0;
            flushD  = 1'b1;
            state_d = REFILL;
          end
        end
        REFILL: begin
          if (redirectE) begin
            // PC already moves to the target, but the stale line is still
            // being written, so wait for its ack in DRAIN.
            flushD         = 1'b1;
            flushE         = 1'b1;
            redirect_taken = 1'b1;
            state_d        = refill_ack ? RUN : DRAIN;
          end else begin
            pc_en  = 1'b0;
            flushD = 1'b1;
            if (refill_ack) begin
              state_d = RUN;
            end
          end
        end
        DRAIN: begin
          pc_en  = 1'b0;
          flushD = 1'b1;
          if (refill_ack) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // Request follows the next state: rises on entry to REFILL and drops the
  // cycle after the ack returns the FSM to RUN.
  always_comb begin
    refill_req_d = (state_d != RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      refill_req_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      refill_req_q <= refill_req_d;
    end
  end

  assign refill_req  = refill_req_q;
  assign miss_active = (state_q == REFILL) || (state_q == DRAIN);

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_active),
    .count (miss_cycles)
  );

  sat_counter #(.W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (redirect_taken),
    .count (redirect_cnt)
  );

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// tb_fetch_hazard_ctrl
// Directed bench for fetch_hazard_ctrl with hand-computed expectations.
// Inputs change at the falling edge, outputs are sampled 1ns later, and
// registered state advances on the following rising edge.
// Control outputs are compared as one vector {pc_en,stallD,stallE,flushD,flushE}.
module tb_fetch_hazard_ctrl;

  localparam int CNT_W = 4;

  localparam logic [4:0] C_RESET  = 5'b00011;
  localparam logic [4:0] C_RUN    = 5'b10000;
  localparam logic [4:0] C_MISS   = 5'b00010;
  localparam logic [4:0] C_REDIR  = 5'b10011;
  localparam logic [4:0] C_LDUSE  = 5'b01001;
  localparam logic [4:0] C_DSTALL = 5'b01100;

  logic             clk;
  logic             rst;
  logic             icache_hitF;
  logic             refill_ack;
  logic             load_use_hazD;
  logic             redirectE;
  logic             dmem_stallM;
  logic             pc_en;
  logic             stallD;
  logic             stallE;
  logic             flushD;
  logic             flushE;
  logic             refill_req;
  logic [CNT_W-1:0] miss_cycles;
  logic [CNT_W-1:0] redirect_cnt;

  int errors;
  int checks;

  fetch_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .icache_hitF   (icache_hitF),
    .refill_ack    (refill_ack),
    .load_use_hazD (load_use_hazD),
    .redirectE     (redirectE),
    .dmem_stallM   (dmem_stallM),
    .pc_en         (pc_en),
    .stallD        (stallD),
    .stallE        (stallE),
    .flushD        (flushD),
    .flushE        (flushE),
    .refill_req    (refill_req),
    .miss_cycles   (miss_cycles),
    .redirect_cnt  (redirect_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then settle.
  task automatic applyStimulus(input logic r, input logic hit, input logic ack,
                               input logic lu, input logic redir, input logic dst);
    @(negedge clk);
    rst           = r;
    icache_hitF   = hit;
    refill_ack    = ack;
    load_use_hazD = lu;
    redirectE     = redir;
    dmem_stallM   = dst;
    #1;
  endtask

  task automatic checkCtrl(input string tag, input logic [4:0] expected);
    checkOutput(tag, {27'd0, pc_en, stallD, stallE, flushD, flushE}, {27'd0, expected});
  endtask

  task automatic doReset();
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1; icache_hitF = 1'b0; refill_ack = 1'b0;
    load_use_hazD = 1'b0; redirectE = 1'b0; dmem_stallM = 1'b0;

    // Reset: forced outputs, cleared registers
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkCtrl("reset_ctrl_c0", C_RESET);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkCtrl("reset_ctrl_c1", C_RESET);
    checkOutput("reset_req", refill_req, 0);
    checkOutput("reset_miss", miss_cycles, 0);
    checkOutput("reset_redir", redirect_cnt, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkCtrl("post_reset_run", C_RUN);

    // Miss at c5, ack at c9
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkCtrl("miss_c5_ctrl", C_MISS);
    checkOutput("miss_c5_req", refill_req, 0);
    for (int i = 6; i <= 8; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkCtrl($sformatf("miss_c%0d_ctrl", i), C_MISS);
      checkOutput($sformatf("miss_c%0d_req", i), refill_req, 1);
    end
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkCtrl("miss_c9_ctrl", C_MISS);
    checkOutput("miss_c9_req", refill_req, 1);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkCtrl("miss_c10_ctrl", C_RUN);
    checkOutput("miss_c10_req", refill_req, 0);
    checkOutput("miss_c10_cnt", miss_cycles, 4);

    // Ack while in RUN is ignored
    applyStimulus(0, 1, 1, 0, 0, 0);
    checkCtrl("stray_ack_ctrl", C_RUN);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("stray_ack_req", refill_req, 0);
    checkOutput("stray_ack_miss", miss_cycles, 4);

    // Redirect during REFILL -> DRAIN, redirect ignored in DRAIN
    doReset();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkCtrl("rdr_miss_ctrl", C_MISS);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("rdr_refill_req", refill_req, 1);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkCtrl("rdr_take_ctrl", C_REDIR);
    checkOutput("rdr_take_cnt", redirect_cnt, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkCtrl("rdr_drain_ctrl", C_MISS);
    checkOutput("rdr_drain_cnt", redirect_cnt, 1);
    checkOutput("rdr_drain_req", refill_req, 1);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkCtrl("rdr_ack_ctrl", C_MISS);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkCtrl("rdr_run_ctrl", C_RUN);
    checkOutput("rdr_run_req", refill_req, 0);
    checkOutput("rdr_run_redir", redirect_cnt, 1);
    checkOutput("rdr_run_miss", miss_cycles, 4);

    // Redirect in REFILL with same-cycle ack goes straight to RUN
    doReset();
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 1, 0);
    checkCtrl("rdr_ack_same_ctrl", C_REDIR);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkCtrl("rdr_ack_same_run", C_RUN);
    checkOutput("rdr_ack_same_req", refill_req, 0);
    checkOutput("rdr_ack_same_miss", miss_cycles, 1);

    // Load-use beats a simultaneous miss
    doReset();
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkCtrl("lu_ctrl", C_LDUSE);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkCtrl("lu_then_miss_ctrl", C_MISS);
    checkOutput("lu_still_run_req", refill_req, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkCtrl("lu_in_refill_ctrl", C_MISS);
    checkOutput("lu_refill_req", refill_req, 1);
    applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkCtrl("lu_back_run", C_RUN);

    // Plain redirect in RUN
    applyStimulus(0, 1, 0, 0, 1, 0);
    checkCtrl("run_redir_ctrl", C_REDIR);

    // dmem stall holds off a redirect for 3 cycles
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 0, 1, 1);
      checkCtrl($sformatf("dst_c%0d_ctrl", i), C_DSTALL);
      checkOutput($sformatf("dst_c%0d_cnt", i), redirect_cnt, 0);
    end
    applyStimulus(0, 1, 0, 0, 1, 0);
    checkCtrl("dst_release_ctrl", C_REDIR);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("dst_release_cnt", redirect_cnt, 1);

    // dmem stall during REFILL: state holds and miss cycles keep counting
    doReset();
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 1);
    checkCtrl("dst_refill_ctrl", C_DSTALL);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkCtrl("dst_refill_hold", C_MISS);
    checkOutput("dst_refill_miss", miss_cycles, 1);
    checkOutput("dst_refill_redir", redirect_cnt, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("dst_refill_miss_end", miss_cycles, 3);

    // Reset mid-refill, late ack ignored
    doReset();
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("mid_rst_req_hi", refill_req, 1);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkCtrl("mid_rst_ctrl", C_RESET);
    applyStimulus(0, 1, 1, 0, 0, 0);
    checkOutput("mid_rst_req_lo", refill_req, 0);
    checkCtrl("mid_rst_late_ack", C_RUN);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("mid_rst_req_stay", refill_req, 0);
    checkOutput("mid_rst_miss", miss_cycles, 0);

    // Saturation: 20 redirects on a 4-bit counter stop at 15
    doReset();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 1, 0, 0, 1, 0);
      if (i == 15) checkOutput("sat_reach15", redirect_cnt, 15);
    end
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("sat_redir", redirect_cnt, 15);

    // Miss counter saturation: 20 REFILL cycles
    doReset();
    for (int i = 0; i < 21; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
    end
    checkOutput("sat_miss", miss_cycles, 15);
    checkOutput("sat_miss_req", refill_req, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_hazard_ctrl.md
Name: fetch_hazard_ctrl

Overview:
Sequences the fetch-stage PC register and the F/D/E pipeline registers.
- Generates the PC enable, stall and flush controls.
- Arbitrates between data-memory stalls, E-stage redirects (branch/JALR), load-use hazards and instruction-cache misses.
- Runs a small refill FSM with handshake to the instruction-memory refill engine.
- Keeps saturating performance counters for miss and redirect cycles.

Parameters:
CNT_W, 16, width of each saturating performance counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
icache_hitF  in  1  F-stage fetch hit; 0 = miss
refill_ack  in  1  single-cycle pulse: refill line written
load_use_hazD  in  1  D-stage instruction depends on load in E
redirectE  in  1  branchE taken OR jalrinsE, valid in E
dmem_stallM  in  1  data memory busy, freezes F..M
pc_en  out  1  PC register enable (drives PC en)
stallD  out  1  hold F/D register
stallE  out  1  hold D/E register
flushD  out  1  clear F/D register to bubble
flushE  out  1  clear D/E register to bubble
refill_req  out  1  level request to refill engine
miss_cycles  out  CNT_W  cycles spent in REFILL or DRAIN
redirect_cnt  out  CNT_W  accepted redirects

Behaviour:
Reset:
- Synchronous, active-high. Next state is RUN, refill_req 0, both counters 0.
- While rst is high, outputs are forced: pc_en 0, stallD 0, stallE 0, flushD 1, flushE 1.

FSM states: RUN, REFILL, DRAIN. State is registered. All control outputs are combinational from state and inputs (zero latency).

Priority, highest first, evaluated every cycle:
1. dmem_stallM=1:
   - pc_en 0, stallD 1, stallE 1, no flushes.
   - State holds.
   - redirectE is ignored this cycle; it is re-presented while E is frozen.
   - Counters still count per their rules.
2. redirectE=1 (RUN or REFILL):
   - pc_en 1, flushD 1, flushE 1, stalls 0.
   - redirect_cnt += 1.
   - In REFILL, next state is DRAIN, unless refill_ack is high that same cycle, in which case next state is RUN.
3. load_use_hazD=1 (RUN only):
   - pc_en 0, stallD 1, flushE 1.
   - This overrides a simultaneous miss; the miss is re-evaluated next cycle.
4. icache_hitF=0 in RUN:
   - pc_en 0, flushD 1.
   - Next state REFILL.
5. Otherwise in RUN: pc_en 1, all stalls/flushes 0.

REFILL, no higher-priority event:
- pc_en 0, flushD 1, stallE 0. E continues draining.
- refill_ack=1 -> next state RUN; the fetch retries and hits.

DRAIN (redirect target already in PC; stale line still filling):
- pc_en 0, flushD 1.
- redirectE is ignored; E holds a bubble by construction.
- refill_ack -> RUN.

refill_req:
- Registered.
- Set on the RUN->REFILL transition.
- Cleared on the cycle after refill_ack is sampled.
- High throughout REFILL and DRAIN, and never high in RUN except on the cycle of the ack.

refill_ack outside REFILL/DRAIN is ignored.

Counters:
- miss_cycles += 1 for each cycle in REFILL or DRAIN.
- Both counters saturate at 2^CNT_W-1; they never wrap.

Reset mid-refill: state returns to RUN, refill_req drops the next cycle, and any late ack is ignored.

Decomposition:
Package fetch_ctrl_pkg:
- enum fetch_state_t {RUN, REFILL, DRAIN}, 2-bit encoding.
- Constant CNT_W_DEFAULT = 16.

One sub-module, sat_counter:
- Parameter W.
- Ports clk, rst, inc, count.
- Instantiated twice.

Test Plan:
- Reset: assert rst 2 cycles with all inputs 0 -> pc_en 0, flushD=flushE=1, refill_req 0, counters 0. Release with hit=1 -> pc_en 1 on the first post-reset cycle.
- Miss: icache_hitF=0 at cycle 5, refill_ack at cycle 9 -> state REFILL in cycles 6..9, refill_req high 6..9 and low at 10, pc_en 0 in cycles 5..9 and 1 at 10, miss_cycles=4.
- Redirect during REFILL at cycle 7 -> pc_en 1 and flushD/flushE 1 at cycle 7; DRAIN in cycles 8..9; refill_ack at 9 -> RUN at 10; redirect_cnt=1.
- Load-use plus simultaneous miss -> load-use wins: stallD 1, flushE 1, state stays RUN. Miss still present next cycle -> REFILL.
- dmem_stallM high for 3 cycles with redirectE high -> pc_en 0, stallD=stallE=1, no flush, redirect_cnt unchanged. On release, the redirect is taken and redirect_cnt=1.
- Saturation with CNT_W=4: 20 consecutive redirects -> redirect_cnt stays at 15.
